// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: groups the scanout, CPU write/read and RAM-side signals of
// vram_arbiter. The arbiter connects through the slave modport; the client/RAM
// side connects through the master modport.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 3
);
  // scanout side
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_blank;
  logic [DATA_W-1:0] disp_q;
  // CPU write side
  logic              cpu_wr_valid;
  logic              cpu_wr_ready;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  // CPU read side
  logic              cpu_rd_valid;
  logic              cpu_rd_ready;
  logic [ADDR_W-1:0] cpu_rd_addr;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdata_vld;
  // RAM macro side
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  disp_req, disp_addr, disp_blank,
    output disp_q,
    input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    output cpu_wr_ready,
    input  cpu_rd_valid, cpu_rd_addr,
    output cpu_rd_ready, cpu_rdata, cpu_rdata_vld,
    output ram_addr, ram_we, ram_wdata,
    input  ram_q
  );

  modport master (
    output disp_req, disp_addr, disp_blank,
    input  disp_q,
    output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    input  cpu_wr_ready,
    output cpu_rd_valid, cpu_rd_addr,
    input  cpu_rd_ready, cpu_rdata, cpu_rdata_vld,
    input  ram_addr, ram_we, ram_wdata,
    output ram_q
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between scanout
// and the CPU. Scanout fetches always win; CPU writes queue in a small FIFO and
// drain on free slots; CPU reads go only when no write is queued, so a read
// never overtakes an earlier write (there is no forwarding path).
// Optional build macro: BLANK_ONLY_EN -- when defined, CPU writes and reads are
// only granted while disp_blank=1 (outside the visible area).
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 3,
  parameter int FIFO_D = 4
) (
  input logic           CLK,
  input logic           RST_N,
  vram_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } gnt_e;

  // write FIFO state
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_D];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_D];
  logic [DATA_W-1:0] fifo_data_q [FIFO_D];
  logic [DATA_W-1:0] fifo_data_d [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // grant pipeline and registered outputs
  gnt_e              last_gnt_q, last_gnt_d;
  logic [DATA_W-1:0] disp_q_q, disp_q_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rdata_vld_q, cpu_rdata_vld_d;

  // combinational grant outputs
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_we;
  logic [DATA_W-1:0] gnt_wdata;
  logic              gnt_rd_ready;
  logic              cpu_ok;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  assign fifo_empty = (count_q == {CNT_W{1'b0}});
  assign fifo_full  = (count_q == CNT_W'(FIFO_D));
  assign push       = bus.cpu_wr_valid && !fifo_full;
  assign pop        = (last_gnt_d == GNT_WR);

  // Decide whether the CPU may use this cycle's slot; reset holds the CPU off so ram_we stays low.
  always_comb begin
    cpu_ok = 1'b0;
`ifdef BLANK_ONLY_EN
    if (RST_N && !bus.disp_req && bus.disp_blank) begin
      cpu_ok = 1'b1;
    end else begin
      cpu_ok = 1'b0;
    end
`else
    if (RST_N && !bus.disp_req) begin
      cpu_ok = 1'b1;
    end else begin
      cpu_ok = 1'b0;
    end
`endif
  end

  // One RAM access per cycle: scanout first, then queued write, then read, else idle.
  always_comb begin
    last_gnt_d   = GNT_IDLE;
    gnt_addr     = {ADDR_W{1'b0}};
    gnt_we       = 1'b0;
    gnt_wdata    = {DATA_W{1'b0}};
    gnt_rd_ready = 1'b0;
    if (bus.disp_req) begin
      last_gnt_d = GNT_DISP;
      gnt_addr   = bus.disp_addr;
    end else if (cpu_ok && !fifo_empty) begin
      last_gnt_d = GNT_WR;
      gnt_addr   = fifo_addr_q[rd_ptr_q];
      gnt_wdata  = fifo_data_q[rd_ptr_q];
      gnt_we     = 1'b1;
    end else if (cpu_ok && bus.cpu_rd_valid) begin
      last_gnt_d   = GNT_RD;
      gnt_addr     = bus.cpu_rd_addr;
      gnt_rd_ready = 1'b1;
    end else begin
      last_gnt_d = GNT_IDLE;
    end
  end

  // Next FIFO contents, pointers and occupancy; simultaneous push and pop keeps the count.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.cpu_wr_addr;
      fifo_data_d[wr_ptr_q] = bus.cpu_wr_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Route RAM read data one cycle after the grant that produced it; displays hold between fetches.
  always_comb begin
    disp_q_d        = disp_q_q;
    cpu_rdata_d     = cpu_rdata_q;
    cpu_rdata_vld_d = 1'b0;
    case (last_gnt_q)
      GNT_DISP: begin
        disp_q_d = bus.ram_q;
      end
      GNT_RD: begin
        cpu_rdata_d     = bus.ram_q;
        cpu_rdata_vld_d = 1'b1;
      end
      default: begin
        cpu_rdata_vld_d = 1'b0;
      end
    endcase
  end

  // State update with synchronous reset; reset also drops any read still in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_D; i++) begin
        fifo_addr_q[i] <= {ADDR_W{1'b0}};
        fifo_data_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q        <= {PTR_W{1'b0}};
      rd_ptr_q        <= {PTR_W{1'b0}};
      count_q         <= {CNT_W{1'b0}};
      last_gnt_q      <= GNT_IDLE;
      disp_q_q        <= {DATA_W{1'b0}};
      cpu_rdata_q     <= {DATA_W{1'b0}};
      cpu_rdata_vld_q <= 1'b0;
    end else begin
      fifo_addr_q     <= fifo_addr_d;
      fifo_data_q     <= fifo_data_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      last_gnt_q      <= last_gnt_d;
      disp_q_q        <= disp_q_d;
      cpu_rdata_q     <= cpu_rdata_d;
      cpu_rdata_vld_q <= cpu_rdata_vld_d;
    end
  end

  assign bus.ram_addr      = gnt_addr;
  assign bus.ram_we        = gnt_we;
  assign bus.ram_wdata     = gnt_wdata;
  assign bus.cpu_rd_ready  = gnt_rd_ready;
  assign bus.cpu_wr_ready  = !fifo_full;
  assign bus.disp_q        = disp_q_q;
  assign bus.cpu_rdata     = cpu_rdata_q;
  assign bus.cpu_rdata_vld = cpu_rdata_vld_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios followed by random traffic, all checked
// every cycle against a queue-and-shadow-memory model of the arbiter rules.
module tb_vram_arbiter;

  localparam int K_IDLE = 0;
  localparam int K_DISP = 1;
  localparam int K_WR   = 2;
  localparam int K_RD   = 3;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  vram_arbiter_if #(.ADDR_W(13), .DATA_W(3)) bus ();

  vram_arbiter #(.ADDR_W(13), .DATA_W(3), .FIFO_D(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // RAM macro: registers the address, returns the stored word next cycle
  logic [2:0] ram_mem [0:8191] = '{default: 3'b000};
  always @(posedge CLK) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= ram_mem[bus.ram_addr];
  end

  // reference model state
  logic [15:0] wq[$];
  logic [2:0]  sh [0:8191];
  logic [2:0]  exp_dq, exp_rd, prev_data;
  logic        exp_vld, warm;
  int          prev_kind;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        acc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_req     = 1'b0;
    bus.disp_addr    = 13'd0;
    bus.cpu_wr_valid = 1'b0;
    bus.cpu_rd_valid = 1'b0;
  endtask

  // one clock: derive expectations from the rules, compare, then advance the model at the edge
  task automatic tick();
    logic [12:0] e_addr;
    logic        e_we, e_rdy, e_wrdy, allow;
    logic [2:0]  e_wdata, kdata;
    int          kind;
    e_addr = 13'd0; e_we = 1'b0; e_rdy = 1'b0; e_wdata = 3'd0; kdata = 3'd0; kind = K_IDLE;
    e_wrdy = (wq.size() < 4);
    allow  = RST_N && !bus.disp_req;
`ifdef BLANK_ONLY_EN
    allow  = allow && bus.disp_blank;
`endif
    if (bus.disp_req) begin
      e_addr = bus.disp_addr; kind = K_DISP; kdata = sh[bus.disp_addr];
    end else if (allow && wq.size() != 0) begin
      e_addr = wq[0][15:3]; e_wdata = wq[0][2:0]; e_we = 1'b1; kind = K_WR;
    end else if (allow && bus.cpu_rd_valid) begin
      e_addr = bus.cpu_rd_addr; e_rdy = 1'b1; kind = K_RD; kdata = sh[bus.cpu_rd_addr];
    end
    #3;
    chk("ram_we", 16'(bus.ram_we), 16'(e_we));
    if (RST_N) begin
      chk("ram_addr", 16'(bus.ram_addr), 16'(e_addr));
      chk("ram_wdata", 16'(bus.ram_wdata), 16'(e_wdata));
      chk("cpu_rd_ready", 16'(bus.cpu_rd_ready), 16'(e_rdy));
    end
    if (warm) begin
      chk("cpu_wr_ready", 16'(bus.cpu_wr_ready), 16'(e_wrdy));
      chk("disp_q", 16'(bus.disp_q), 16'(exp_dq));
      chk("cpu_rdata", 16'(bus.cpu_rdata), 16'(exp_rd));
      chk("cpu_rdata_vld", 16'(bus.cpu_rdata_vld), 16'(exp_vld));
    end
    @(posedge CLK);
    if (!RST_N) begin
      wq.delete();
      exp_dq = 3'd0; exp_rd = 3'd0; exp_vld = 1'b0;
      prev_kind = K_IDLE; prev_data = 3'd0; warm = 1'b1;
    end else begin
      exp_vld = 1'b0;
      if (prev_kind == K_DISP) exp_dq = prev_data;
      if (prev_kind == K_RD) begin exp_rd = prev_data; exp_vld = 1'b1; end
      if (kind == K_WR) begin sh[e_addr] = e_wdata; void'(wq.pop_front()); end
      if (bus.cpu_wr_valid && e_wrdy) wq.push_back({bus.cpu_wr_addr, bus.cpu_wr_data});
      prev_kind = kind; prev_data = kdata;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) sh[i] = 3'd0;
    warm = 1'b0; exp_dq = 3'd0; exp_rd = 3'd0; exp_vld = 1'b0;
    prev_kind = K_IDLE; prev_data = 3'd0;
    idle_inputs();
    bus.disp_blank  = 1'b1;
    bus.cpu_wr_addr = 13'd0;
    bus.cpu_wr_data = 3'd0;
    bus.cpu_rd_addr = 13'd0;

    // reset state
    RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    settle();
    chk("reset_wr_ready", 16'(bus.cpu_wr_ready), 16'd1);
    chk("reset_vld", 16'(bus.cpu_rdata_vld), 16'd0);
    chk("reset_disp_q", 16'(bus.disp_q), 16'd0);

    // single write reaches the RAM the cycle after the push
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 13'h0123; bus.cpu_wr_data = 3'b101;
    tick();
    bus.cpu_wr_valid = 1'b0;
    settle();
    chk("t1_we", 16'(bus.ram_we), 16'd1);
    chk("t1_addr", 16'(bus.ram_addr), 16'h0123);
    chk("t1_wdata", 16'(bus.ram_wdata), 16'b101);
    tick();
    settle();
    chk("t1_we_after", 16'(bus.ram_we), 16'd0);

    // FIFO fills behind scanout, drains in order, fifth write waits for room
    bus.disp_req = 1'b1; bus.disp_addr = 13'h0007;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 13'(32'h20 + i); bus.cpu_wr_data = 3'(i + 1);
      settle();
      chk("t2_ready_fill", 16'(bus.cpu_wr_ready), 16'd1);
      tick();
    end
    bus.cpu_wr_addr = 13'h0024; bus.cpu_wr_data = 3'd5;
    settle();
    chk("t2_full", 16'(bus.cpu_wr_ready), 16'd0);
    tick();
    bus.disp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_drain_we", 16'(bus.ram_we), 16'd1);
      chk("t2_drain_addr", 16'(bus.ram_addr), 16'(32'h20 + i));
      chk("t2_drain_data", 16'(bus.ram_wdata), 16'(i + 1));
      acc = bus.cpu_wr_valid && bus.cpu_wr_ready;
      tick();
      if (acc) bus.cpu_wr_valid = 1'b0;
    end
    settle();
    chk("t2_fifth_addr", 16'(bus.ram_addr), 16'h0024);
    chk("t2_fifth_data", 16'(bus.ram_wdata), 16'd5);
    tick();

    // read waits for the queued write to the same address, then returns it
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 13'h0010; bus.cpu_wr_data = 3'b011;
    tick();
    bus.cpu_wr_valid = 1'b0;
    bus.disp_req = 1'b1; bus.disp_addr = 13'h0001;
    bus.cpu_rd_valid = 1'b1; bus.cpu_rd_addr = 13'h0010;
    settle(); chk("t3_rdy_disp0", 16'(bus.cpu_rd_ready), 16'd0); tick();
    settle(); chk("t3_rdy_disp1", 16'(bus.cpu_rd_ready), 16'd0); tick();
    bus.disp_req = 1'b0;
    settle(); chk("t3_rdy_drain", 16'(bus.cpu_rd_ready), 16'd0); chk("t3_drain_we", 16'(bus.ram_we), 16'd1); tick();
    settle(); chk("t3_rdy_grant", 16'(bus.cpu_rd_ready), 16'd1); tick();
    bus.cpu_rd_valid = 1'b0;
    tick();
    settle();
    chk("t3_vld", 16'(bus.cpu_rdata_vld), 16'd1);
    chk("t3_rdata", 16'(bus.cpu_rdata), 16'b011);
    tick();

    // scanout beats a pending read
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 13'h0050; bus.cpu_wr_data = 3'b110;
    tick();
    bus.cpu_wr_valid = 1'b0;
    tick();
    bus.disp_req = 1'b1; bus.disp_addr = 13'h0050;
    bus.cpu_rd_valid = 1'b1; bus.cpu_rd_addr = 13'h0033;
    settle();
    chk("t4_rd_ready", 16'(bus.cpu_rd_ready), 16'd0);
    chk("t4_addr", 16'(bus.ram_addr), 16'h0050);
    tick();
    idle_inputs();
    tick();
    settle();
    chk("t4_disp_q", 16'(bus.disp_q), 16'b110);
    tick();

    // reset with writes queued discards them
    bus.disp_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 13'(32'h60 + i); bus.cpu_wr_data = 3'(7 - i);
      tick();
    end
    idle_inputs();
    RST_N = 1'b0;
    settle();
    chk("t5_we_in_reset", 16'(bus.ram_we), 16'd0);
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t5_we", 16'(bus.ram_we), 16'd0);
      chk("t5_wr_ready", 16'(bus.cpu_wr_ready), 16'd1);
      chk("t5_vld", 16'(bus.cpu_rdata_vld), 16'd0);
      tick();
    end

    // visible area with no fetch: write held off only in the blank-only build
    bus.disp_blank = 1'b0;
    bus.cpu_wr_valid = 1'b1; bus.cpu_wr_addr = 13'h0040; bus.cpu_wr_data = 3'b111;
    tick();
    bus.cpu_wr_valid = 1'b0;
    settle();
`ifdef BLANK_ONLY_EN
    chk("t6_held0", 16'(bus.ram_we), 16'd0);
    tick();
    settle();
    chk("t6_held1", 16'(bus.ram_we), 16'd0);
    tick();
    bus.disp_blank = 1'b1;
    settle();
    chk("t6_release", 16'(bus.ram_we), 16'd1);
`else
    chk("t6_no_gating", 16'(bus.ram_we), 16'd1);
`endif
    tick();
    bus.disp_blank = 1'b1;
    tick();

    // random traffic including addresses beyond the visible map and occasional resets
    for (int n = 0; n < 1500; n++) begin
      bus.disp_req     = ($urandom_range(0, 99) < 35);
      bus.disp_addr    = 13'($urandom_range(0, 31));
      bus.disp_blank   = ($urandom_range(0, 99) < 60);
      bus.cpu_wr_valid = ($urandom_range(0, 99) < 45);
      bus.cpu_wr_addr  = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(4800, 8191)) : 13'($urandom_range(0, 31));
      bus.cpu_wr_data  = 3'($urandom);
      bus.cpu_rd_valid = ($urandom_range(0, 99) < 40);
      bus.cpu_rd_addr  = ($urandom_range(0, 9) == 0) ? bus.cpu_wr_addr : 13'($urandom_range(0, 31));
      RST_N            = ($urandom_range(0, 199) != 0);
      tick();
    end
    RST_N = 1'b1;
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
